seq_divider32: RTL and testbench
================================

SEQ_DIVIDER32 -- requirements
Module: seq_divider32

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 sign  input  1  1 = signed two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 dividend  input  32  numerator; sampled with start.
REQ-007 divisor  input  32  denominator; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 quotient  output  32  result quotient (LO).
REQ-011 remainder  output  32  result remainder (HI).
REQ-012 div_zero  output  1  divisor was zero; valid with done, held until next done.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, FIX, with IDLE as the reset state.
REQ-014 IDLE & start at edge E0 -> CALC; operands, sign and div_zero are captured; iteration count = 0; busy = 1.
REQ-015 CALC SHALL perform one restoring-division step per edge for 32 edges (E1..E32), then go to FIX.
REQ-016 Each step: shift {rem, quo} left by 1; compute the 33-bit trial rem - |divisor|; if the trial is non-negative, keep it and set the quotient LSB to 1, else restore and set it to 0.
REQ-017 At edge E33, FIX SHALL load quotient/remainder, pulse done = 1 for exactly one cycle, drop busy and return to IDLE; fixed latency is 33 edges from start to done, including the divide-by-zero case.
REQ-018 Signed mode: operate on magnitudes; negate the quotient if the operand signs differ; the remainder takes the sign of the dividend (truncating division).
REQ-019 0x80000000 / 0xFFFFFFFF signed SHALL wrap: quotient = 0x80000000, remainder = 0, div_zero = 0.
REQ-020 Divisor == 0: div_zero = 1, quotient = 0xFFFFFFFF, remainder = dividend (unmodified), for both signed and unsigned.
REQ-021 start while busy SHALL be ignored with no queuing; start in the cycle done is high (already IDLE) SHALL be accepted.
REQ-022 quotient, remainder and div_zero SHALL change only at the FIX edge and hold between operations.
REQ-023 Operand inputs may change freely after the start edge without affecting the result.

Reset
REQ-024 rst = 1 at any edge, including mid-CALC, SHALL force IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, and abort the operation silently.
REQ-025 If rst and start are high on the same edge, rst SHALL win and start is dropped.

Structure
REQ-026 The shared package SHALL hold the data width (32), the iteration count (32), and the state encodings IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10.
REQ-027 The single combinational sub-module div_step SHALL implement REQ-016 (inputs: partial remainder, quotient, divisor magnitude; outputs: next remainder, next quotient).
REQ-028 Total RTL SHALL be within 120-400 lines; there SHALL be no multiplier or "/" operator in synthesized logic.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Unsigned 100 / 7 -> quotient = 14, remainder = 2, done exactly 33 edges after start, busy high E0..E32.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1); same operands unsigned -> quotient = 0x7FFFFFFC, remainder = 1.
- Divisor 0, dividend 0x12345678 -> div_zero = 1, quotient = 0xFFFFFFFF, remainder = 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0; unsigned 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0.
- start re-pulsed at E10 with different operands -> ignored, first result returned; start in the done cycle -> second result 33 edges later.
- rst at E15 -> next cycle busy = 0, outputs 0, no done; a subsequent 9 / 3 -> quotient = 3, remainder = 0.

Source files
------------

// File: rtl/seq_divider32_pkg.sv
// Shared widths, FSM encoding and a sign-fixup helper for the sequential 32-bit divider.
package seq_divider32_pkg;

  localparam int DATA_W = 32;
  localparam int ITER_N = 32;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // Two's-complement negate when neg is set; 0x80000000 wraps onto itself.
  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                     input logic              neg);
    if (neg) begin
      cond_negate = ~v + 32'd1;
    end else begin
      cond_negate = v;
    end
  endfunction

endpackage

// File: rtl/seq_divider32_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_divider32_if;
  import seq_divider32_pkg::*;

  logic              start;
  logic              sign;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_zero;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/seq_divider32_div_step.sv
// One restoring-division step on magnitudes: shift {rem, quo} left and try to subtract.
module div_step
  import seq_divider32_pkg::*;
(
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_dvs,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_trial;

  // Bit DATA_W of the 33-bit trial is set exactly when the shifted remainder is below the divisor.
  always_comb begin
    w_shift = {i_rem, i_quo[DATA_W-1]};
    w_trial = w_shift - {1'b0, i_dvs};
    if (!w_trial[DATA_W]) begin
      o_rem = w_trial[DATA_W-1:0];
      o_quo = {i_quo[DATA_W-2:0], 1'b1};
    end else begin
      o_rem = w_shift[DATA_W-1:0];
      o_quo = {i_quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider32.sv
// Sequential 32-bit signed/unsigned divider: capture, 32 restoring steps, then sign fix-up.
module seq_divider32
  import seq_divider32_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  seq_divider32_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs_mag;
  logic [DATA_W-1:0] r_dividend;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz_pend;
  logic              r_busy;
  logic              r_done;
  logic              r_div_zero;
  logic [DATA_W-1:0] r_quotient;
  logic [DATA_W-1:0] r_remainder;
  logic              w_load;
  logic              w_step;
  logic              w_fix;
  logic [DATA_W-1:0] w_step_rem;
  logic [DATA_W-1:0] w_step_quo;
  logic [DATA_W-1:0] w_dvd_mag;
  logic [DATA_W-1:0] w_dvs_mag;

  assign w_dvd_mag = cond_negate(bus.dividend, bus.sign & bus.dividend[DATA_W-1]);
  assign w_dvs_mag = cond_negate(bus.divisor,  bus.sign & bus.divisor[DATA_W-1]);

  div_step u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs_mag),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next_state = ST_CALC;
        else           w_next_state = ST_IDLE;
      end
      ST_CALC: begin
        if (r_cnt == LAST_CNT) w_next_state = ST_FIX;
        else                   w_next_state = ST_CALC;
      end
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      ST_IDLE: w_load = bus.start;
      ST_CALC: w_step = 1'b1;
      ST_FIX:  w_fix  = 1'b1;
      default: begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration registers and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 5'd0;
      r_rem       <= 32'd0;
      r_quo       <= 32'd0;
      r_dvs_mag   <= 32'd0;
      r_dividend  <= 32'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz_pend   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_cnt      <= 5'd0;
        r_rem      <= 32'd0;
        r_quo      <= w_dvd_mag;
        r_dvs_mag  <= w_dvs_mag;
        r_dividend <= bus.dividend;
        r_neg_q    <= bus.sign & (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
        r_neg_r    <= bus.sign & bus.dividend[DATA_W-1];
        r_dz_pend  <= (bus.divisor == 32'd0);
        r_busy     <= 1'b1;
      end else if (w_step) begin
        r_cnt <= r_cnt + 5'd1;
        r_rem <= w_step_rem;
        r_quo <= w_step_quo;
      end else if (w_fix) begin
        r_busy     <= 1'b0;
        r_div_zero <= r_dz_pend;
        // Divide-by-zero reports all-ones and the raw dividend regardless of signed mode.
        if (r_dz_pend) begin
          r_quotient  <= 32'hFFFF_FFFF;
          r_remainder <= r_dividend;
        end else begin
          r_quotient  <= cond_negate(r_quo, r_neg_q);
          r_remainder <= cond_negate(r_rem, r_neg_r);
        end
      end else begin
        r_busy <= r_busy;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider32.sv
// Randomized + directed bench for seq_divider32; a monitor checks every done against a queued model result.
module tb_seq_divider32;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  seq_divider32_if bus();

  seq_divider32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.cyc = 0;
    e.dz  = 1'b0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Assumes we are #1 after an edge with the DUT idle; returns #1 after the start edge E0.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.start    = 1'b1;
    bus.sign     = s;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    e     = model(s, a, b);
    e.cyc = cyc + 33;
    sb.push_back(e);
    bus.start    = 1'b0;
    bus.sign     = ~s;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // Waits through E1..E33 while scrambling inputs and poking start; ends #1 after E33.
  task automatic wait_done(input bit noisy);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (noisy && k <= 32) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.sign     = 1'($urandom_range(0, 1));
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: cyc=%0d q=%h r=%h, no result outstanding",
                   cyc, bus.quotient, bus.remainder);
        end else begin
          e = sb.pop_front();
          if (bus.quotient !== e.q || bus.remainder !== e.r ||
              bus.div_zero !== e.dz || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL result: got q=%h r=%h dz=%b cyc=%0d, expected q=%h r=%h dz=%b cyc=%0d",
                     bus.quotient, bus.remainder, bus.div_zero, cyc, e.q, e.r, e.dz, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic        bad;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    cyc          = 0;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.sign     = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_quo", bus.quotient, 32'd0);
    chk("rst_rem", bus.remainder, 32'd0);
    chk("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 100 / 7 with busy profile E0..E33 and hold afterwards
    issue(1'b0, 32'd100, 32'd7);
    bad = (bus.busy !== 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (k <= 32) bad = bad | (bus.busy !== 1'b1) | (bus.done !== 1'b0);
      else         bad = bad | (bus.busy !== 1'b0) | (bus.done !== 1'b1);
    end
    chk("busy_done_profile", {31'd0, bad}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("hold_quo", bus.quotient, 32'd14);
    chk("hold_rem", bus.remainder, 32'd2);

    issue(1'b1, 32'hFFFF_FFF9, 32'd2);       wait_done(1'b1);
    issue(1'b0, 32'hFFFF_FFF9, 32'd2);       wait_done(1'b1);
    issue(1'b0, 32'h1234_5678, 32'd0);       wait_done(1'b1);
    issue(1'b1, 32'h1234_5678, 32'd0);       wait_done(1'b1);
    issue(1'b1, 32'h8765_4321, 32'd0);       wait_done(1'b1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(1'b1);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);       wait_done(1'b0);
    @(posedge clk); #1;
    chk("hold_dz_cleared", {31'd0, bus.div_zero}, 32'd0);

    // start re-pulsed at E10 is ignored; start in the done cycle is taken
    issue(1'b0, 32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    chk("done_cycle_flag", {31'd0, bus.done}, 32'd1);
    issue(1'b1, 32'hFFFF_FC18, 32'd7);       wait_done(1'b0);
    @(posedge clk); #1;

    // reset at E15 aborts silently
    issue(1'b0, 32'd5000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_quo", bus.quotient, 32'd0);
    chk("abort_rem", bus.remainder, 32'd0);
    repeat (25) @(posedge clk);
    #1;
    issue(1'b0, 32'd9, 32'd3);               wait_done(1'b0);
    @(posedge clk); #1;

    // rst and start on the same edge: rst wins
    rst = 1'b1; bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rst_beats_start", {31'd0, bus.busy}, 32'd0);

    // randomized operations, some back-to-back
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(s, a, b);
      wait_done(1'b1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    repeat (40) @(posedge clk);
    #1;

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL outstanding: %0d results never reported, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
